carbon_mmio_sysctl: RTL and testbench
=====================================

// Module: carbon_mmio_sysctl
// PURPOSE
//  Fabric target for the simulation/system-control MMIO window; downstream consumer of bring-up masters.
//  Decodes single-beat fabric requests and returns one response per request, echoing the request id.
//  Holds the SIGNATURE register, the sticky POWEROFF latch and a free-running CYCLES counter.
//  Exports signature/poweroff status to the testbench or top level.
// PARAMETERS
//  MMIO_BASE    32'h0000_0000  byte base of the sysctl window
//  WINDOW_BYTES 256            decoded window size; power of two, >= 16
//  RSP_DEPTH    2              response FIFO entries; >= 1
// PORTS
//  clk            in   1   single clock
//  rst_n          in   1   reset; asynchronous, active-low
//  fab            slave fabric_if  request/response channel (widths from the interface)
//  signature      out  32  SIGNATURE register contents
//  signature_seen out  1   sticky; set by any accepted SIGNATURE write
//  poweroff       out  1   sticky power-off request
//  console_valid  out  1   [CARBON_MMIO_SYSCTL_CONSOLE_EN only] one-cycle console byte strobe
//  console_data   out  8   [CARBON_MMIO_SYSCTL_CONSOLE_EN only] console byte
// BEHAVIOUR
//  Reset: signature=0, signature_seen=0, poweroff=0, cycles=0, FIFO empty, fab.rsp_valid=0, console_valid=0.
//  fab.req_ready = (fifo count < RSP_DEPTH). No same-cycle bypass: when full, req_ready=0 even if rsp_fire.
//  req_fire = req_valid && req_ready. Decode and side effects happen on that edge; response pushed the same edge.
//  Latency: rsp_valid rises the cycle after req_fire when the FIFO was empty. Responses return in order.
//  fab.rsp_valid = FIFO non-empty. Head is popped on rsp_fire. Push and pop in one cycle keep the count.
//  Response carries rsp_id = req_id, rsp_code, and rsp_rdata. rdata is 0 for writes and errors.
//  Decode off = req_addr - MMIO_BASE.
//   DECERR when out of window, addr[1:0]!=0, unknown offset, or op not READ/WRITE. DECERR has no side effect.
//  SIGNATURE_OFF: WRITE merges bytes per wstrb into signature and sets signature_seen. READ returns signature.
//  POWEROFF_OFF: WRITE with wstrb[0] && wdata[0] sets poweroff. poweroff is never cleared except by reset.
//    Other POWEROFF writes are OK with no effect. READ returns {31'b0, poweroff}.
//  CYCLES_OFF: read-only, 32-bit, +1 every cycle out of reset, wraps 0xFFFF_FFFF->0. A WRITE returns DECERR.
//  A WRITE with wstrb==0 is OK with no effect.
//  req_size is ignored. Accesses are 32-bit and wstrb selects the bytes.
//  Reset mid-transaction drops FIFO contents. No response is owed afterward.
// CONFIGURATION
//  `define CARBON_MMIO_SYSCTL_CONSOLE_EN
//   With: CONSOLE_OFF WRITE with wstrb[0] pulses console_valid for one cycle after req_fire,
//     with console_data = wdata[7:0]. Reads of CONSOLE_OFF return 0.
//   Without: console ports are absent and CONSOLE_OFF decodes as DECERR.
// STRUCTURE
//  carbon_memmap_pkg holds CARBON_MMIO_{SIGNATURE,POWEROFF,CYCLES,CONSOLE}_OFF.
//  carbon_arch_pkg holds CARBON_FABRIC_XACT_{READ,WRITE} and CARBON_FABRIC_RSP_{OK,DECERR}.
//  Local typedef rsp_ent_t = {id, code, rdata}.
//  Sub-module carbon_fabric_rsp_fifo(DEPTH, type/width of rsp_ent_t): circular buffer,
//    push/pop/full/empty, count width $clog2(DEPTH+1).
// TESTING
//  1 Write 0xC0DE_CAFE, wstrb=F, id=3 to SIGNATURE -> next cycle OK/id 3; signature=0xC0DECAFE, signature_seen=1.
//  2 Write SIGNATURE wstrb=4'b0010, wdata=0x0000_AB00 after (1) -> signature=0xC0DEABFE; read returns the same.
//  3 Write POWEROFF wdata=1, wstrb=1 -> poweroff=1 and stays 1. Later write wdata=0 -> still 1, OK.
//  4 Hold rsp_ready=0 and issue 3 requests with RSP_DEPTH=2 -> req_ready=0 after 2 accepts.
//    Release -> ids return in order; the third request is accepted only after a pop.
//  5 Access MMIO_BASE+WINDOW_BYTES, MMIO_BASE+2, and a CYCLES write -> DECERR, rdata=0, state unchanged.
//  6 Read CYCLES twice N cycles apart -> delta == N.
//    Console build: write 0x41 to CONSOLE -> one-cycle console_valid, console_data=0x41.

Source files
------------

// File: rtl/carbon_arch_pkg.sv
// Fabric-wide architectural constants: transaction types, response codes and
// the channel field widths shared by every fabric_if endpoint.
package carbon_arch_pkg;

  localparam int unsigned CARBON_FABRIC_ID_W   = 4;
  localparam int unsigned CARBON_FABRIC_ADDR_W = 32;
  localparam int unsigned CARBON_FABRIC_DATA_W = 32;
  localparam int unsigned CARBON_FABRIC_OP_W   = 2;
  localparam int unsigned CARBON_FABRIC_SIZE_W = 3;
  localparam int unsigned CARBON_FABRIC_CODE_W = 2;

  typedef enum logic [CARBON_FABRIC_OP_W-1:0] {
    CARBON_FABRIC_XACT_NONE   = 2'd0,
    CARBON_FABRIC_XACT_READ   = 2'd1,
    CARBON_FABRIC_XACT_WRITE  = 2'd2,
    CARBON_FABRIC_XACT_ATOMIC = 2'd3
  } carbon_fabric_xact_e;

  typedef enum logic [CARBON_FABRIC_CODE_W-1:0] {
    CARBON_FABRIC_RSP_OK     = 2'd0,
    CARBON_FABRIC_RSP_DECERR = 2'd3
  } carbon_fabric_rsp_e;

endpackage

// File: rtl/carbon_memmap_pkg.sv
// Byte offsets of the registers inside the system-control MMIO window.
package carbon_memmap_pkg;

  localparam logic [31:0] CARBON_MMIO_SIGNATURE_OFF = 32'h0000_0000;
  localparam logic [31:0] CARBON_MMIO_POWEROFF_OFF  = 32'h0000_0004;
  localparam logic [31:0] CARBON_MMIO_CYCLES_OFF    = 32'h0000_0008;
  localparam logic [31:0] CARBON_MMIO_CONSOLE_OFF   = 32'h0000_000C;

endpackage

// File: rtl/fabric_if.sv
// Single-beat request/response fabric channel; the target drives req_ready
// and the whole response side.
interface fabric_if;

  logic                                                req_valid;
  logic                                                req_ready;
  logic [carbon_arch_pkg::CARBON_FABRIC_ID_W-1:0]      req_id;
  logic [carbon_arch_pkg::CARBON_FABRIC_OP_W-1:0]      req_op;
  logic [carbon_arch_pkg::CARBON_FABRIC_ADDR_W-1:0]    req_addr;
  logic [carbon_arch_pkg::CARBON_FABRIC_SIZE_W-1:0]    req_size;
  logic [carbon_arch_pkg::CARBON_FABRIC_DATA_W-1:0]    req_wdata;
  logic [carbon_arch_pkg::CARBON_FABRIC_DATA_W/8-1:0]  req_wstrb;

  logic                                                rsp_valid;
  logic                                                rsp_ready;
  logic [carbon_arch_pkg::CARBON_FABRIC_ID_W-1:0]      rsp_id;
  logic [carbon_arch_pkg::CARBON_FABRIC_CODE_W-1:0]    rsp_code;
  logic [carbon_arch_pkg::CARBON_FABRIC_DATA_W-1:0]    rsp_rdata;

  modport master (
    output req_valid, req_id, req_op, req_addr, req_size, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_code, rsp_rdata
  );

  modport slave (
    input  req_valid, req_id, req_op, req_addr, req_size, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_code, rsp_rdata
  );

endinterface

// File: rtl/carbon_fabric_rsp_fifo.sv
// Circular-buffer response FIFO; push into a full FIFO and pop from an empty
// one are ignored so the pointers can never cross.
module carbon_fabric_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/carbon_mmio_sysctl.sv
// System-control MMIO target: SIGNATURE, sticky POWEROFF, free-running CYCLES.
// Define CARBON_MMIO_SYSCTL_CONSOLE_EN to add the CONSOLE byte-output register.
module carbon_mmio_sysctl
  import carbon_arch_pkg::*;
  import carbon_memmap_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE    = 32'h0000_0000,
  parameter int unsigned WINDOW_BYTES = 256,
  parameter int unsigned RSP_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fabric_if.slave     fab,
  output logic [31:0] signature,
  output logic        signature_seen,
  output logic        poweroff
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
  ,
  output logic        console_valid,
  output logic [7:0]  console_data
`endif
);

  typedef struct packed {
    logic [CARBON_FABRIC_ID_W-1:0]   id;
    logic [CARBON_FABRIC_CODE_W-1:0] code;
    logic [CARBON_FABRIC_DATA_W-1:0] rdata;
  } rsp_ent_t;

  localparam int unsigned ENT_W = $bits(rsp_ent_t);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  logic [31:0]                     signature_q, signature_d;
  logic                            seen_q, seen_d;
  logic                            poweroff_q, poweroff_d;
  logic [31:0]                     cycles_q;
  logic [31:0]                     off;
  logic                            in_win, aligned, op_rd, op_wr;
  logic [CARBON_FABRIC_CODE_W-1:0] rsp_code;
  logic [31:0]                     rsp_rdata;
  logic                            req_ready, req_fire, rsp_fire;
  logic                            fifo_full, fifo_empty;
  logic [CNT_W-1:0]                unused_fifo_count;
  logic [CARBON_FABRIC_SIZE_W-1:0] unused_req_size;
  rsp_ent_t                        push_ent, head_ent;
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
  logic                            con_hit;
  logic                            con_valid_q;
  logic [7:0]                      con_data_q;
`endif

  // No bypass: a full FIFO blocks requests even while the head is popping.
  assign req_ready       = !fifo_full;
  assign req_fire        = fab.req_valid && req_ready;
  assign rsp_fire        = !fifo_empty && fab.rsp_ready;
  assign unused_req_size = fab.req_size;

  always_comb begin
    off         = fab.req_addr - MMIO_BASE;
    in_win      = (off < WINDOW_BYTES);
    aligned     = (fab.req_addr[1:0] == 2'b00);
    op_rd       = (fab.req_op == CARBON_FABRIC_XACT_READ);
    op_wr       = (fab.req_op == CARBON_FABRIC_XACT_WRITE);
    rsp_code    = CARBON_FABRIC_RSP_DECERR;
    rsp_rdata   = '0;
    signature_d = signature_q;
    seen_d      = seen_q;
    poweroff_d  = poweroff_q;
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
    con_hit     = 1'b0;
`endif
    if (in_win && aligned && (op_rd || op_wr)) begin
      case (off)
        CARBON_MMIO_SIGNATURE_OFF: begin
          rsp_code = CARBON_FABRIC_RSP_OK;
          if (op_rd) begin
            rsp_rdata = signature_q;
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (fab.req_wstrb[b]) signature_d[8*b +: 8] = fab.req_wdata[8*b +: 8];
            end
            seen_d = seen_q | (|fab.req_wstrb);
          end
        end
        CARBON_MMIO_POWEROFF_OFF: begin
          rsp_code = CARBON_FABRIC_RSP_OK;
          if (op_rd) begin
            rsp_rdata = {31'b0, poweroff_q};
          end else if (fab.req_wstrb[0] && fab.req_wdata[0]) begin
            poweroff_d = 1'b1;
          end
        end
        CARBON_MMIO_CYCLES_OFF: begin
          if (op_rd) begin
            rsp_code  = CARBON_FABRIC_RSP_OK;
            rsp_rdata = cycles_q;
          end
        end
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
        CARBON_MMIO_CONSOLE_OFF: begin
          rsp_code = CARBON_FABRIC_RSP_OK;
          con_hit  = op_wr && fab.req_wstrb[0];
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    push_ent       = '0;
    push_ent.id    = fab.req_id;
    push_ent.code  = rsp_code;
    push_ent.rdata = rsp_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature_q <= '0;
      seen_q      <= 1'b0;
      poweroff_q  <= 1'b0;
      cycles_q    <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (req_fire) begin
        signature_q <= signature_d;
        seen_q      <= seen_d;
        poweroff_q  <= poweroff_d;
      end
    end
  end

`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
    end else begin
      con_valid_q <= req_fire && con_hit;
      if (req_fire && con_hit) con_data_q <= fab.req_wdata[7:0];
    end
  end

  assign console_valid = con_valid_q;
  assign console_data  = con_data_q;
`endif

  carbon_fabric_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (ENT_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (req_fire),
    .push_data_i (push_ent),
    .pop_i       (rsp_fire),
    .pop_data_o  (head_ent),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (unused_fifo_count)
  );

  assign fab.req_ready   = req_ready;
  assign fab.rsp_valid   = !fifo_empty;
  assign fab.rsp_id      = head_ent.id;
  assign fab.rsp_code    = head_ent.code;
  assign fab.rsp_rdata   = head_ent.rdata;

  assign signature      = signature_q;
  assign signature_seen = seen_q;
  assign poweroff       = poweroff_q;

endmodule

// File: tb/tb_carbon_mmio_sysctl.sv
// Bench for carbon_mmio_sysctl: directed requests, a transaction-level model
// with an expected-response queue, and literal checks on key results.
module tb_carbon_mmio_sysctl;
  import carbon_arch_pkg::*;
  import carbon_memmap_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int unsigned WIN  = 256;
  localparam int unsigned DEP  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fabric_if fab();
  logic [31:0] signature;
  logic        signature_seen, poweroff;
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
  logic        console_valid;
  logic [7:0]  console_data;
`endif

  carbon_mmio_sysctl #(.MMIO_BASE(BASE), .WINDOW_BYTES(WIN), .RSP_DEPTH(DEP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fab            (fab),
    .signature      (signature),
    .signature_seen (signature_seen),
    .poweroff       (poweroff)
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
    ,
    .console_valid  (console_valid),
    .console_data   (console_data)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model state
  typedef struct {
    logic [3:0]  id;
    logic [1:0]  code;
    logic [31:0] rdata;
  } exp_t;
  exp_t        expq[$];
  logic [31:0] m_sig;
  bit          m_seen, m_pwr;
  logic [31:0] m_cyc;
  bit          exp_con;
  logic [7:0]  exp_con_data;

  // Observations handed to the directed checks
  logic [3:0]  last_id;
  logic [1:0]  last_code;
  logic [31:0] last_rdata;
  int          rsp_cnt = 0;
  logic [3:0]  popped_ids[$];
  time         pop_t[$];
  int          con_cnt = 0;
  logic [7:0]  con_last;

  task automatic model_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] cyc,
                           output logic [1:0] code, output logic [31:0] rdata, output bit con);
    longint unsigned a, rel;
    logic [31:0] mask;
    code  = CARBON_FABRIC_RSP_DECERR;
    rdata = 32'h0;
    con   = 1'b0;
    a     = longint'(addr);
    if (a < longint'(BASE) || a >= longint'(BASE) + WIN || (a % 4) != 0) return;
    if (op != CARBON_FABRIC_XACT_READ && op != CARBON_FABRIC_XACT_WRITE) return;
    rel = a - longint'(BASE);
    if (rel == 0) begin
      code = CARBON_FABRIC_RSP_OK;
      if (op == CARBON_FABRIC_XACT_READ) rdata = m_sig;
      else begin
        mask  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        m_sig = (m_sig & ~mask) | (wdata & mask);
        if (wstrb != 0) m_seen = 1'b1;
      end
    end else if (rel == 4) begin
      code = CARBON_FABRIC_RSP_OK;
      if (op == CARBON_FABRIC_XACT_READ) rdata = {31'b0, m_pwr};
      else if (wstrb[0] && wdata[0]) m_pwr = 1'b1;
    end else if (rel == 8) begin
      if (op == CARBON_FABRIC_XACT_READ) begin
        code  = CARBON_FABRIC_RSP_OK;
        rdata = cyc;
      end
    end else if (rel == 12) begin
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
      code = CARBON_FABRIC_RSP_OK;
      con  = (op == CARBON_FABRIC_XACT_WRITE) && wstrb[0];
`endif
    end
  endtask

  // Compare process: one sample per cycle, midway between active edges.
  always @(negedge clk) begin
    exp_t        e;
    logic [1:0]  c;
    logic [31:0] r;
    bit          cn;
    if (!rst_n) begin
      expq.delete();
      m_sig = 0; m_seen = 0; m_pwr = 0; m_cyc = 0; exp_con = 0;
      chk("rst_rsp_valid", fab.rsp_valid, 0);
      chk("rst_signature", signature, 0);
      chk("rst_seen", signature_seen, 0);
      chk("rst_poweroff", poweroff, 0);
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
      chk("rst_console_valid", console_valid, 0);
`endif
    end else begin
      chk("rsp_valid", fab.rsp_valid, expq.size() != 0);
      chk("req_ready", fab.req_ready, expq.size() < DEP);
      chk("signature", signature, m_sig);
      chk("signature_seen", signature_seen, m_seen);
      chk("poweroff", poweroff, m_pwr);
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
      chk("console_valid", console_valid, exp_con);
      if (exp_con) chk("console_data", console_data, exp_con_data);
      if (console_valid) begin
        con_cnt++;
        con_last = console_data;
      end
`endif
      exp_con = 1'b0;
      if (fab.rsp_valid && fab.rsp_ready && expq.size() != 0) begin
        e = expq.pop_front();
        chk("rsp_id", fab.rsp_id, e.id);
        chk("rsp_code", fab.rsp_code, e.code);
        chk("rsp_rdata", fab.rsp_rdata, e.rdata);
        last_id    = fab.rsp_id;
        last_code  = fab.rsp_code;
        last_rdata = fab.rsp_rdata;
        popped_ids.push_back(fab.rsp_id);
        pop_t.push_back($time);
        rsp_cnt++;
      end
      if (fab.req_valid && fab.req_ready) begin
        model_req(fab.req_op, fab.req_addr, fab.req_wdata, fab.req_wstrb, m_cyc, c, r, cn);
        e.id = fab.req_id; e.code = c; e.rdata = r;
        expq.push_back(e);
        exp_con      = cn;
        exp_con_data = fab.req_wdata[7:0];
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  // Drivers: entered and left at 1 time unit after a rising edge.
  task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [3:0] id, output time t_fire);
    bit acc = 1'b0;
    fab.req_valid = 1'b1;
    fab.req_op    = op;
    fab.req_addr  = addr;
    fab.req_wdata = wdata;
    fab.req_wstrb = wstrb;
    fab.req_id    = id;
    fab.req_size  = 3'd2;
    t_fire        = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (fab.req_ready) begin
        acc    = 1'b1;
        t_fire = $time;
        break;
      end
    end
    chk("req_accepted", acc, 1);
    @(posedge clk);
    #1;
    fab.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    bit got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_cnt >= target) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("rsp_arrived", got, 1);
  endtask

  task automatic xact(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [3:0] id, output time t_fire);
    int prev = rsp_cnt;
    do_req(op, addr, wdata, wstrb, id, t_fire);
    wait_rsp(prev + 1);
  endtask

  localparam logic [1:0] RD = CARBON_FABRIC_XACT_READ;
  localparam logic [1:0] WR = CARBON_FABRIC_XACT_WRITE;
  localparam logic [1:0] OK = CARBON_FABRIC_RSP_OK;
  localparam logic [1:0] DE = CARBON_FABRIC_RSP_DECERR;

  initial begin
    time         t, t1, t2, t3;
    logic [31:0] r1, r2;
    int          base_cnt;
    fab.req_valid = 0; fab.req_op = 0; fab.req_addr = 0; fab.req_size = 0;
    fab.req_wdata = 0; fab.req_wstrb = 0; fab.req_id = 0; fab.rsp_ready = 1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First CYCLES read right out of reset sees 0, the back-to-back one sees 2.
    xact(RD, BASE + CARBON_MMIO_CYCLES_OFF, 0, 0, 4'd1, t1);
    chk("cyc_first", last_rdata, 32'd0);
    xact(RD, BASE + CARBON_MMIO_CYCLES_OFF, 0, 0, 4'd2, t2);
    chk("cyc_second", last_rdata, 32'd2);

    // SIGNATURE full write, then byte-merge and readback
    xact(WR, BASE + CARBON_MMIO_SIGNATURE_OFF, 32'hC0DE_CAFE, 4'hF, 4'd3, t);
    chk("t1_id", last_id, 4'd3);
    chk("t1_code", last_code, OK);
    chk("t1_rdata", last_rdata, 32'h0);
    chk("t1_signature", signature, 32'hC0DE_CAFE);
    chk("t1_seen", signature_seen, 1);
    xact(WR, BASE + CARBON_MMIO_SIGNATURE_OFF, 32'h0000_AB00, 4'b0010, 4'd4, t);
    chk("t2_signature", signature, 32'hC0DE_ABFE);
    xact(RD, BASE + CARBON_MMIO_SIGNATURE_OFF, 0, 0, 4'd5, t);
    chk("t2_read", last_rdata, 32'hC0DE_ABFE);
    xact(WR, BASE + CARBON_MMIO_SIGNATURE_OFF, 32'hFFFF_FFFF, 4'h0, 4'd6, t);
    chk("wstrb0_code", last_code, OK);
    chk("wstrb0_signature", signature, 32'hC0DE_ABFE);

    // POWEROFF is sticky
    xact(WR, BASE + CARBON_MMIO_POWEROFF_OFF, 32'h1, 4'h1, 4'd7, t);
    chk("t3_poweroff", poweroff, 1);
    xact(WR, BASE + CARBON_MMIO_POWEROFF_OFF, 32'h0, 4'h1, 4'd8, t);
    chk("t3_code", last_code, OK);
    chk("t3_sticky", poweroff, 1);
    xact(RD, BASE + CARBON_MMIO_POWEROFF_OFF, 0, 0, 4'd9, t);
    chk("t3_read", last_rdata, 32'h1);

    // Decode errors leave state untouched
    xact(RD, BASE + WIN, 0, 0, 4'd10, t);
    chk("t5_oow_code", last_code, DE);
    chk("t5_oow_rdata", last_rdata, 32'h0);
    xact(WR, BASE + 32'd2, 32'hFFFF_FFFF, 4'hF, 4'd11, t);
    chk("t5_unaligned_code", last_code, DE);
    chk("t5_unaligned_sig", signature, 32'hC0DE_ABFE);
    xact(WR, BASE + CARBON_MMIO_CYCLES_OFF, 32'h1234, 4'hF, 4'd12, t);
    chk("t5_cycwr_code", last_code, DE);
    chk("t5_cycwr_rdata", last_rdata, 32'h0);
    xact(RD, BASE - 32'd4, 0, 0, 4'd13, t);
    chk("below_base_code", last_code, DE);
    xact(CARBON_FABRIC_XACT_ATOMIC, BASE + CARBON_MMIO_SIGNATURE_OFF, 32'h0, 4'hF, 4'd14, t);
    chk("bad_op_code", last_code, DE);
    chk("bad_op_sig", signature, 32'hC0DE_ABFE);
    xact(RD, BASE + 32'h20, 0, 0, 4'd15, t);
    chk("unknown_off_code", last_code, DE);

    // CONSOLE
    base_cnt = con_cnt;
    xact(WR, BASE + CARBON_MMIO_CONSOLE_OFF, 32'h41, 4'h1, 4'd1, t);
`ifdef CARBON_MMIO_SYSCTL_CONSOLE_EN
    chk("con_code", last_code, OK);
    chk("con_pulses", con_cnt - base_cnt, 1);
    chk("con_data", con_last, 8'h41);
    xact(RD, BASE + CARBON_MMIO_CONSOLE_OFF, 0, 0, 4'd2, t);
    chk("con_read", last_rdata, 32'h0);
`else
    chk("con_decerr", last_code, DE);
`endif

    // CYCLES delta over idle gap
    xact(RD, BASE + CARBON_MMIO_CYCLES_OFF, 0, 0, 4'd3, t1);
    r1 = last_rdata;
    repeat (5) @(posedge clk);
    #1;
    xact(RD, BASE + CARBON_MMIO_CYCLES_OFF, 0, 0, 4'd4, t2);
    r2 = last_rdata;
    chk("t6_delta", r2 - r1, 32'd7);
    chk("t6_delta_time", r2 - r1, (t2 - t1) / 10);

    // Backpressure with a two-entry FIFO
    popped_ids.delete();
    pop_t.delete();
    base_cnt      = rsp_cnt;
    fab.rsp_ready = 1'b0;
    fork
      begin
        do_req(RD, BASE + CARBON_MMIO_SIGNATURE_OFF, 0, 0, 4'd5, t);
        do_req(RD, BASE + CARBON_MMIO_POWEROFF_OFF, 0, 0, 4'd6, t);
        do_req(WR, BASE + CARBON_MMIO_SIGNATURE_OFF, 32'h1111_2222, 4'hF, 4'd7, t3);
      end
      begin
        repeat (4) @(negedge clk);
        chk("t4_ready_low", fab.req_ready, 0);
        chk("t4_rsp_valid", fab.rsp_valid, 1);
        @(posedge clk);
        #1;
        fab.rsp_ready = 1'b1;
      end
    join
    wait_rsp(base_cnt + 3);
    chk("t4_npops", popped_ids.size(), 3);
    if (popped_ids.size() == 3) begin
      chk("t4_id0", popped_ids[0], 4'd5);
      chk("t4_id1", popped_ids[1], 4'd6);
      chk("t4_id2", popped_ids[2], 4'd7);
      chk("t4_third_after_pop", t3 > pop_t[0], 1);
    end
    chk("t4_signature", signature, 32'h1111_2222);

    // Reset with a response pending drops it
    fab.rsp_ready = 1'b0;
    do_req(WR, BASE + CARBON_MMIO_SIGNATURE_OFF, 32'hDEAD_BEEF, 4'hF, 4'd9, t);
    chk("pre_rst_valid", fab.rsp_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", fab.rsp_valid, 0);
    chk("midrst_signature", signature, 32'h0);
    chk("midrst_poweroff", poweroff, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fab.rsp_ready = 1'b1;
    xact(RD, BASE + CARBON_MMIO_CYCLES_OFF, 0, 0, 4'd10, t);
    chk("post_rst_cyc", last_rdata, 32'd0);
    chk("post_rst_id", last_id, 4'd10);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", fab.rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
